// File: rtl/tv80_bus_model.sv
// TV80 bus slave model: byte memory and I/O arrays, per-space wait states, optional write trace.
// Define TV80_BUS_MODEL_TRACE_EN to build the write-trace FIFO; otherwise its outputs are tied to 0.
module tv80_bus_model #(
  parameter int ADDR_W      = 16,
  parameter int IO_AW       = 8,
  parameter int MEM_WAIT    = 0,
  parameter int IO_WAIT     = 1,
  parameter int TRACE_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] a,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  input  logic        trace_pop,
  output logic        trace_valid,
  output logic [24:0] trace_data,
  output logic        trace_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_armed;
  logic [7:0]         r_di;
  logic               r_wait_n;
  logic [7:0]         r_mem [2**ADDR_W];
  logic [7:0]         r_io  [2**IO_AW];

  logic               w_intack;
  logic               w_strobe_idle;
  logic               w_start;
  logic               w_write;
  logic [3:0]         w_wait_load;
  logic [ADDR_W-1:0]  w_maddr;
  logic [IO_AW-1:0]   w_ioaddr;

  assign w_maddr       = a[ADDR_W-1:0];
  assign w_ioaddr      = a[IO_AW-1:0];
  assign w_intack      = !m1_n && !iorq_n;
  assign w_strobe_idle = rd_n && wr_n;
  // r_armed blocks a restart when reset is released while the CPU still holds its strobes.
  assign w_start       = (r_state == S_IDLE) && r_armed && rfsh_n && !w_intack &&
                         (!mreq_n || !iorq_n) && !w_strobe_idle;
  assign w_write       = w_start && !wr_n;
  assign w_wait_load   = iorq_n ? 4'(MEM_WAIT) : 4'(IO_WAIT);

  assign di     = r_di;
  assign wait_n = r_wait_n;

  always_ff @(negedge clk) begin
    if (w_write && iorq_n)  r_mem[w_maddr] <= dout;
    if (w_write && !iorq_n) r_io[w_ioaddr] <= dout;
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_di     <= 8'h00;
      r_wait_n <= 1'b1;
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_armed  <= 1'b0;
    end else begin
      if (w_intack)     r_di <= 8'hFF;
      else if (!iorq_n) r_di <= r_io[w_ioaddr];
      else              r_di <= r_mem[w_maddr];

      if (w_strobe_idle) r_armed <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt    <= w_wait_load;
            r_wait_n <= (w_wait_load == 4'd0);
            r_state  <= (w_wait_load == 4'd0) ? S_HOLD : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_strobe_idle) begin
            r_cnt    <= 4'd0;
            r_wait_n <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_cnt    <= r_cnt - 4'd1;
            r_wait_n <= (r_cnt == 4'd1);
            if (r_cnt == 4'd1) r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_strobe_idle) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef TV80_BUS_MODEL_TRACE_EN
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam logic [PW:0] DEPTH_C = TRACE_DEPTH[PW:0];

  logic [24:0]  r_fifo [TRACE_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]  r_count;
  logic         r_ovf;
  logic         w_full;
  logic         w_pop;
  logic         w_push;

  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = trace_pop && (r_count != '0);
  // At full a simultaneous pop frees the slot the push needs.
  assign w_push = w_write && (!w_full || w_pop);

  always_ff @(negedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {!iorq_n, a, dout};
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_write && !w_push) r_ovf <= 1'b1;
    end
  end

  assign trace_valid = (r_count != '0);
  assign trace_data  = trace_valid ? r_fifo[r_rd_ptr] : 25'd0;
  assign trace_ovf   = r_ovf;
`else
  logic w_unused_trace;
  assign w_unused_trace = trace_pop ^ (^a);
  assign trace_valid    = 1'b0;
  assign trace_data     = 25'd0;
  assign trace_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_tv80_bus_model.sv
// Directed bench for tv80_bus_model: read-data and write-trace scoreboards checked with immediate assertions.
module tb_tv80_bus_model;
  localparam int MEM_WAIT = 0;
  localparam int IO_WAIT  = 2;
  localparam int DEPTH    = 16;
`ifdef TV80_BUS_MODEL_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        reset_n, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, trace_pop;
  logic [15:0] a;
  logic [7:0]  dout, di;
  logic        wait_n, trace_valid, trace_ovf;
  logic [24:0] trace_data;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_di_q[$];
  logic [24:0] exp_trace_q[$];
  logic        exp_ovf = 1'b0;

  always #5 clk = ~clk;

  tv80_bus_model #(
    .ADDR_W(12), .IO_AW(8), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .a(a), .dout(dout), .di(di),
    .wait_n(wait_n), .trace_pop(trace_pop), .trace_valid(trace_valid),
    .trace_data(trace_data), .trace_ovf(trace_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One falling (active) edge, then sample half a period later.
  task automatic edge_step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic trace_check(input string tag);
    chk({tag, "_valid"}, 32'(trace_valid), 32'(exp_trace_q.size() != 0));
    chk({tag, "_data"}, 32'(trace_data), 32'((exp_trace_q.size() != 0) ? exp_trace_q[0] : 25'd0));
    chk({tag, "_ovf"}, 32'(trace_ovf), 32'(exp_ovf));
  endtask

  task automatic model_push(input logic [24:0] e, input bit pop);
    if (TRACE_ON) begin
      if (pop && exp_trace_q.size() != 0) void'(exp_trace_q.pop_front());
      if (exp_trace_q.size() < DEPTH) exp_trace_q.push_back(e);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic run_access(input string tag, input int n_exp);
    int n = 0;
    edge_step();
    trace_pop = 1'b0;
    while (wait_n === 1'b0 && n < 20) begin
      n++;
      edge_step();
    end
    chk({tag, "_waits"}, 32'(n), 32'(n_exp));
  endtask

  task automatic bus_write(input string tag, input bit is_io, input logic [15:0] addr,
                           input logic [7:0] data, input bit pop);
    a = addr; dout = data; wr_n = 1'b0; trace_pop = pop;
    if (is_io) iorq_n = 1'b0; else mreq_n = 1'b0;
    model_push({is_io, addr, data}, pop);
    run_access(tag, is_io ? IO_WAIT : MEM_WAIT);
    bus_idle();
    edge_step();
  endtask

  task automatic bus_read(input string tag, input bit is_io, input logic [15:0] addr,
                          input logic [7:0] exp);
    a = addr; rd_n = 1'b0;
    if (is_io) iorq_n = 1'b0; else mreq_n = 1'b0;
    exp_di_q.push_back(exp);
    run_access(tag, is_io ? IO_WAIT : MEM_WAIT);
    chk({tag, "_di"}, 32'(di), 32'(exp_di_q.pop_front()));
    bus_idle();
    edge_step();
  endtask

  task automatic drain_trace(input string tag);
    int n = 0;
    int n_exp = exp_trace_q.size();
    while (trace_valid === 1'b1 && n < 40) begin
      chk({tag, "_head"}, 32'(trace_data),
          32'((exp_trace_q.size() != 0) ? exp_trace_q[0] : 25'd0));
      trace_pop = 1'b1;
      edge_step();
      trace_pop = 1'b0;
      n++;
      if (exp_trace_q.size() != 0) void'(exp_trace_q.pop_front());
    end
    chk({tag, "_count"}, 32'(n), 32'(n_exp));
    trace_check(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus_idle();
    a = 16'h0000; dout = 8'h00; trace_pop = 1'b0; reset_n = 1'b0;
    edge_step();
    edge_step();
    chk("rst_di", 32'(di), 32'h00);
    chk("rst_wait", 32'(wait_n), 32'h1);
    trace_check("rst");
    reset_n = 1'b1;
    edge_step();

    // Preload through the bus, then confirm reset keeps memory contents.
    bus_write("wr394d", 1'b0, 16'h394D, 8'h10, 1'b0);
    trace_check("wr394d");
    reset_n = 1'b0;
    #1;
    exp_trace_q.delete();
    exp_ovf = 1'b0;
    edge_step();
    chk("rst2_di", 32'(di), 32'h00);
    chk("rst2_wait", 32'(wait_n), 32'h1);
    trace_check("rst2");
    reset_n = 1'b1;
    edge_step();
    bus_read("rd394d", 1'b0, 16'h394D, 8'h10);

    bus_write("iowr", 1'b1, 16'h12FE, 8'h5A, 1'b0);
    trace_check("iowr");
    drain_trace("iowr_pop");
    bus_read("iord", 1'b1, 16'h00FE, 8'h5A);

    bus_write("wrap_wr", 1'b0, 16'hF123, 8'hA7, 1'b0);
    bus_read("wrap_rd", 1'b0, 16'h0123, 8'hA7);
    trace_check("wrap");
    drain_trace("wrap_pop");

    m1_n = 1'b0; iorq_n = 1'b0;
    exp_di_q.push_back(8'hFF);
    edge_step();
    chk("inta_di", 32'(di), 32'(exp_di_q.pop_front()));
    chk("inta_wait", 32'(wait_n), 32'h1);
    bus_idle();
    edge_step();

    bus_write("pre_rf", 1'b0, 16'h0456, 8'h33, 1'b0);
    drain_trace("pre_rf_pop");
    a = 16'h0456; dout = 8'hCC; rfsh_n = 1'b0; mreq_n = 1'b0; wr_n = 1'b0;
    edge_step();
    chk("rfsh_wait", 32'(wait_n), 32'h1);
    edge_step();
    bus_idle();
    edge_step();
    trace_check("rfsh");
    bus_read("rfsh_rd", 1'b0, 16'h0456, 8'h33);

    for (int i = 0; i < 17; i++)
      bus_write("ovf_wr", 1'b0, 16'(16'h0200 + i), 8'(i) ^ 8'h3C, 1'b0);
    trace_check("ovf");
    bus_write("full_pp", 1'b0, 16'h0300, 8'hE1, 1'b1);
    trace_check("full_pp");
    drain_trace("full_drain");

    // Reset in the middle of an I/O write, strobes still held after release.
    a = 16'h0011; dout = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
    edge_step();
    chk("mid_wait_lo", 32'(wait_n), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wait", 32'(wait_n), 32'h1);
    exp_trace_q.delete();
    exp_ovf = 1'b0;
    edge_step();
    reset_n = 1'b1;
    edge_step();
    edge_step();
    chk("mid_hold_wait", 32'(wait_n), 32'h1);
    trace_check("mid");
    bus_idle();
    edge_step();
    bus_read("mid_rd", 1'b1, 16'h0011, 8'h77);
    trace_check("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
